twophase_sender: RTL and testbench

- Clocked transmitter for the two-phase (transition-signalled) bundled-data channel; drives the `req`/`data_out` side that the asynchronous receiver samples when `req != ack`.
- Buffers words from a synchronous valid/ready source in a small FIFO.
- Holds each word stable for a bundling setup delay, toggles `req`, then waits for the synchronised `ack` to match `req` before sending the next word.

---
 rtl/twophase_pkg.sv | 18 +
 rtl/twophase_sync.sv | 28 ++
 rtl/twophase_sender.sv | 177 +++++++++++++++++
 tb/tb_twophase_sender.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/twophase_pkg.sv
// Shared types and defaults for the two-phase bundled-data sender.
package twophase_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/twophase_sync.sv
// Flop-chain synchroniser for an asynchronous single-bit input, reset to 0.
module twophase_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/twophase_sender.sv
// Two-phase bundled-data transmitter with an input FIFO and synchronised ack.
// Optional WAIT_ACK timeout flag: define TWOPHASE_SENDER_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | nothing in flight; pops the FIFO head once req matches ack_s
// SETUP    | data_out held, counting down before the req toggle
// WAIT_ACK | req toggled, waiting for ack_s to match req
module twophase_sender
    import twophase_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = 2,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack,
    output logic             busy
`ifdef TWOPHASE_SENDER_TIMEOUT_EN
   ,output logic             timeout
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full_q, full_d;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_s;
    logic             pending;
    logic             push;
    logic             pop;
    logic             empty;

    twophase_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack),
        .q   (ack_s)
    );

    assign pending = req_q ^ ack_s;
    assign empty   = (count_q == '0);
    // in_ready looks only at the registered flag, so a pop never frees a slot early
    assign push    = in_valid & ~full_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !pending) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    cnt_d   = CNT_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_ACK: begin
                if (!pending) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        data_d  = mem_q[rd_ptr_q];
                        cnt_d   = CNT_LOAD;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
        full_d   = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            data_q   <= data_d;
        end
    end

`ifdef TWOPHASE_SENDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYC);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        if (state_d == WAIT_ACK && state_q != WAIT_ACK) begin
            tcnt_d = '0;
        end else if (state_q == WAIT_ACK && tcnt_q != T_LIMIT) begin
            tcnt_d = tcnt_q + TW'(1);
        end
        if (state_q == WAIT_ACK && tcnt_d == T_LIMIT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign in_ready = ~full_q;
    assign req      = req_q;
    assign data_out = data_q;
    assign busy     = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_twophase_sender.sv
// Directed bench for twophase_sender: cycle vector table plus corner-case sequences.
module tb_twophase_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       req;
    logic [7:0] data_out;
    logic       ack;
    logic       busy;
`ifdef TWOPHASE_SENDER_TIMEOUT_EN
    logic       timeout;
`endif

    always #5 clk = ~clk;

    twophase_sender #(
        .WIDTH       (8),
        .DEPTH       (2),
        .SETUP_CYC   (2),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req      (req),
        .data_out (data_out),
        .ack      (ack),
        .busy     (busy)
`ifdef TWOPHASE_SENDER_TIMEOUT_EN
       ,.timeout  (timeout)
`endif
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] din;
        logic       ack;
        logic       e_req;
        logic [7:0] e_data;
        logic       e_ready;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic iv, input logic [7:0] d, input logic a,
                       input logic er, input logic [7:0] ed, input logic erd, input logic eb);
        vec_t v;
        v.rst = r; v.iv = iv; v.din = d; v.ack = a;
        v.e_req = er; v.e_data = ed; v.e_ready = erd; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic wait_req(input logic target, input int limit, output int n);
        n = 0;
        while (req !== target && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] words [3];
        int         wi, toggles, last_change, last_toggle;
        logic [7:0] last_data;
        logic       last_req, r_old, r_new, accept, saw_full, moved;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack = 1'b0;

        // rst iv din ack | req data ready busy
        add(1, 0, 8'h00, 0,  0, 8'h00, 1, 0);
        add(0, 1, 8'hA5, 0,  0, 8'h00, 1, 1);
        add(0, 0, 8'h00, 0,  0, 8'hA5, 1, 1);
        add(0, 0, 8'h00, 0,  0, 8'hA5, 1, 1);
        add(0, 0, 8'h00, 0,  1, 8'hA5, 1, 1);
        add(0, 0, 8'h00, 0,  1, 8'hA5, 1, 1);
        add(0, 0, 8'h00, 1,  1, 8'hA5, 1, 1);
        add(0, 0, 8'h00, 1,  1, 8'hA5, 1, 1);
        add(0, 0, 8'h00, 1,  1, 8'hA5, 1, 0);
        add(0, 1, 8'hC1, 1,  1, 8'hA5, 1, 1);
        add(0, 1, 8'hC2, 1,  1, 8'hC1, 1, 1);
        add(0, 1, 8'hC3, 1,  1, 8'hC1, 0, 1);
        add(0, 1, 8'hC4, 1,  0, 8'hC1, 0, 1);
        for (int k = 0; k < 4; k++) add(0, 0, 8'h00, 1,  0, 8'hC1, 0, 1);
        add(0, 0, 8'h00, 0,  0, 8'hC1, 0, 1);
        add(0, 0, 8'h00, 0,  0, 8'hC1, 0, 1);
        add(0, 0, 8'h00, 0,  0, 8'hC2, 1, 1);
        add(0, 0, 8'h00, 0,  0, 8'hC2, 1, 1);
        add(0, 0, 8'h00, 0,  1, 8'hC2, 1, 1);
        add(0, 0, 8'h00, 1,  1, 8'hC2, 1, 1);
        add(0, 0, 8'h00, 1,  1, 8'hC2, 1, 1);
        add(0, 0, 8'h00, 1,  1, 8'hC3, 1, 1);
        add(0, 0, 8'h00, 1,  1, 8'hC3, 1, 1);
        add(0, 0, 8'h00, 1,  0, 8'hC3, 1, 1);
        add(0, 0, 8'h00, 0,  0, 8'hC3, 1, 1);
        add(0, 0, 8'h00, 0,  0, 8'hC3, 1, 1);
        add(0, 0, 8'h00, 0,  0, 8'hC3, 1, 0);
        add(0, 0, 8'h00, 0,  0, 8'hC3, 1, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].din; ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d req", i),      req,      vecs[i].e_req);
            check($sformatf("vec%0d data_out", i), data_out, vecs[i].e_data);
            check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ready);
            check($sformatf("vec%0d busy", i),     busy,     vecs[i].e_busy);
        end
        in_valid = 1'b0;

        // Back-to-back with a responder echoing req one cycle late
        rst = 1'b1; ack = 1'b0; tick(); rst = 1'b0;
        check("b2b reset req", req, 0);
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        wi = 0; toggles = 0; last_change = 0; last_toggle = 0;
        last_data = data_out; last_req = req; r_old = req; r_new = req; saw_full = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            in_valid = (wi < 3);
            in_data  = words[(wi < 3) ? wi : 0];
            accept   = in_valid && in_ready;
            ack      = r_old;
            tick();
            if (accept) wi++;
            if (!in_ready) saw_full = 1'b1;
            if (data_out !== last_data) begin
                if (toggles > 0) check("b2b ack-to-load gap", cyc - last_toggle, 4);
                last_data = data_out; last_change = cyc;
            end
            if (req !== last_req) begin
                if (toggles < 3) check($sformatf("b2b word%0d", toggles), data_out, words[toggles]);
                check("b2b setup hold", cyc - last_change, 2);
                toggles++; last_toggle = cyc; last_req = req;
            end
            r_old = r_new; r_new = req;
        end
        in_valid = 1'b0;
        check("b2b toggles", toggles, 3);
        check("b2b all pushed", wi, 3);
        check("b2b in_ready low seen", saw_full, 1);
        check("b2b final busy", busy, 0);

        // Reset in WAIT_ACK with req=1 and ack=1
        rst = 1'b1; ack = 1'b0; tick(); rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h77; tick(); in_valid = 1'b0;
        wait_req(1'b1, 10, n);
        check("rst setup req", req, 1);
        ack = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
        check("rst req", req, 0);
        check("rst data_out", data_out, 8'h00);
        check("rst busy", busy, 0);
        check("rst in_ready", in_ready, 1);
        tick(); tick(); tick();
        in_valid = 1'b1; in_data = 8'h5A; tick(); in_valid = 1'b0;
        moved = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req !== 1'b0 || data_out !== 8'h00) moved = 1'b1;
        end
        check("rst blocked while pending", moved, 0);
        check("rst blocked busy", busy, 1);
        ack = 1'b0;
        wait_req(1'b1, 12, n);
        check("rst drain req", req, 1);
        check("rst drain latency", n, 5);
        check("rst drain data", data_out, 8'h5A);
        ack = 1'b1;
        wait_idle(10);
        check("rst drain idle", busy, 0);

        // Spurious ack toggle while idle
        ack = 1'b0;
        moved = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (req !== 1'b1 || busy !== 1'b0) moved = 1'b1;
        end
        check("spur idle quiet", moved, 0);
        in_valid = 1'b1; in_data = 8'h3C; tick(); in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (req !== 1'b1 || data_out !== 8'h5A) moved = 1'b1;
        end
        check("spur push blocked", moved, 0);
        check("spur busy", busy, 1);
        ack = 1'b1;
        wait_req(1'b0, 12, n);
        check("spur resume req", req, 0);
        check("spur resume data", data_out, 8'h3C);
        ack = 1'b0;
        wait_idle(10);
        check("spur idle", busy, 0);

`ifdef TWOPHASE_SENDER_TIMEOUT_EN
        in_valid = 1'b1; in_data = 8'h99; tick(); in_valid = 1'b0;
        wait_req(1'b1, 10, n);
        check("to req", req, 1);
        check("to at entry", timeout, 0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("to cycle%0d", k), timeout, (k >= 10) ? 1 : 0);
        end
        check("to data held", data_out, 8'h99);
        rst = 1'b1; tick(); rst = 1'b0;
        check("to cleared", timeout, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
